// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the instruction-memory loader.
package mips_pkg;

   localparam int unsigned DefAddrW   = 8;
   localparam int unsigned DefTimeout = 1024;

   typedef enum logic [2:0] {
      StIdle,
      StRecv,
      StWrite,
      StDone,
      StErr
   } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
interface imem_loader_if #(
   parameter int unsigned ADDR_W = mips_pkg::DefAddrW
) ();

   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_wr_addr;
   logic [31:0]       imem_wr_data;

   // master is the loader side
   modport master (
      input  byte_valid,
      input  byte_data,
      output byte_ready,
      output imem_wr_en,
      output imem_wr_addr,
      output imem_wr_data
   );

   modport slave (
      output byte_valid,
      output byte_data,
      input  byte_ready,
      input  imem_wr_en,
      input  imem_wr_addr,
      input  imem_wr_data
   );

endinterface

// File: rtl/byte_packer.sv
// Assembles four MSB-first bytes into a 32-bit word with a wrapping 2-bit byte counter.
module byte_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        last
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q, cnt_d;

   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (shift_en) begin
         word_d = {word_q[23:0], byte_in};
         cnt_d  = cnt_q + 2'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
      end
   end

   assign word = word_q;
   // Fourth byte of the word is being taken on this edge.
   assign last = shift_en && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit words and writes them to instruction memory while holding the CPU.
module imem_loader
   import mips_pkg::*;
#(
   parameter int unsigned ADDR_W  = DefAddrW,
   parameter int unsigned TIMEOUT = DefTimeout
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            start,
   input  logic [ADDR_W:0] word_count,
   output logic            cpu_hold,
   output logic            done,
   output logic            err,
   imem_loader_if.master   bus
);

   localparam int unsigned     TmoW     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W:0] MaxCount = {1'b1, {ADDR_W{1'b0}}};

   loader_state_e     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [TmoW-1:0]   tmo_q, tmo_d;
   logic [ADDR_W:0]   count_clamped;
   logic              accept;
   logic              word_last;
   logic              packer_clear;
   logic [31:0]       word;

   assign count_clamped = (word_count > MaxCount) ? MaxCount : word_count;
   assign accept        = bus.byte_valid && (state_q == StRecv);

   byte_packer u_packer (
      .clock    (clock),
      .reset    (reset),
      .clear    (packer_clear),
      .shift_en (accept),
      .byte_in  (bus.byte_data),
      .word     (word),
      .last     (word_last)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      packer_clear = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d        = count_clamped;
               addr_d       = '0;
               tmo_d        = '0;
               packer_clear = 1'b1;
               state_d      = (count_clamped == '0) ? StDone : StRecv;
            end
         end
         StRecv: begin
            if (accept) begin
               tmo_d = '0;
               if (word_last) state_d = StWrite;
            end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
               state_d = StErr;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StWrite: begin
            // Count is at most 2^ADDR_W, so the last address never exceeds the counter range.
            if ({1'b0, addr_q} == cnt_q - 1'b1) begin
               state_d = StDone;
            end else begin
               addr_d  = addr_q + 1'b1;
               tmo_d   = '0;
               state_d = StRecv;
            end
         end
         StDone, StErr: state_d = StIdle;
         default:       state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         cnt_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.byte_ready   = (state_q == StRecv);
   assign bus.imem_wr_en   = (state_q == StWrite);
   assign bus.imem_wr_addr = addr_q;
   assign bus.imem_wr_data = word;
   assign cpu_hold         = (state_q != StIdle);
   assign done             = (state_q == StDone);
   assign err              = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; expected memory writes go through a scoreboard queue.
module tb_imem_loader;

   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned TIMEOUT = 16;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic            clock = 1'b0;
   logic            reset;
   logic            start;
   logic [ADDR_W:0] word_count;
   logic            cpu_hold;
   logic            done;
   logic            err;

   int          compared   = 0;
   int          mismatched = 0;
   int unsigned cyc        = 0;
   int          wr_count   = 0;
   logic [ADDR_W-1:0] last_addr = '0;
   wr_t         sb[$];
   wr_t         exp_w;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(
      .ADDR_W  (ADDR_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .bus        (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest expected entry.
   always @(negedge clock) begin
      if (bus.imem_wr_en === 1'b1) begin
         wr_count++;
         last_addr = bus.imem_wr_addr;
         check("sb_has_entry", 64'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            exp_w = sb.pop_front();
            check("wr_addr", 64'(bus.imem_wr_addr), 64'(exp_w.addr));
            check("wr_data", 64'(bus.imem_wr_data), 64'(exp_w.data));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      while (bus.byte_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("byte_ready", 64'(bus.byte_ready), 1);
      tick();
      bus.byte_valid = 1'b0;
   endtask

   task automatic start_load(input logic [ADDR_W:0] count);
      start      = 1'b1;
      word_count = count;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_flag(input bit want_err, input string tag, output int unsigned at);
      int n = 0;
      while (((want_err ? err : done) !== 1'b1) && n < 64) begin
         tick();
         n++;
      end
      check(tag, 64'(want_err ? err : done), 1);
      at = cyc;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_byte_ready"}, 64'(bus.byte_ready), 0);
      check({tag, "_wr_en"}, 64'(bus.imem_wr_en), 0);
      check({tag, "_wr_addr"}, 64'(bus.imem_wr_addr), 0);
      check({tag, "_wr_data"}, 64'(bus.imem_wr_data), 0);
      check({tag, "_cpu_hold"}, 64'(cpu_hold), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_err"}, 64'(err), 0);
   endtask

   function automatic logic [31:0] pat(input int i);
      return {8'(i), 8'(~i), 8'hA5, 8'(i * 7)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t_first, t_last, t_done, t_err;
      int          wr_before;
      logic [31:0] w;

      reset          = 1'b1;
      start          = 1'b0;
      word_count     = '0;
      bus.byte_valid = 1'b0;
      bus.byte_data  = '0;
      repeat (2) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Two-word load, valid held high between bytes.
      sb.push_back(wr_t'{addr: 8'd0, data: 32'h20080005});
      sb.push_back(wr_t'{addr: 8'd1, data: 32'h8C090004});
      start_load(9'd2);
      check("load_cpu_hold", 64'(cpu_hold), 1);
      check("load_byte_ready", 64'(bus.byte_ready), 1);
      send_byte(8'h20);
      t_first = cyc;
      send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
      send_byte(8'h8C); send_byte(8'h09); send_byte(8'h00); send_byte(8'h04);
      wait_flag(1'b0, "load_done", t_done);
      // Inclusive from the first accept cycle: two words at 5 cycles each.
      check("done_latency", 64'(t_done - t_first + 1), 10);
      check("load_writes", 64'(wr_count), 2);
      tick();
      check("done_pulse_width", 64'(done), 0);
      check("hold_released", 64'(cpu_hold), 0);

      // Zero-length load goes straight to DONE.
      wr_before = wr_count;
      start_load(9'd0);
      check("zero_done", 64'(done), 1);
      check("zero_no_ready", 64'(bus.byte_ready), 0);
      tick();
      check("zero_done_once", 64'(done), 0);
      check("zero_idle", 64'(cpu_hold), 0);
      check("zero_no_write", 64'(wr_count - wr_before), 0);

      // Stall after two bytes: TIMEOUT idle RECV cycles, then err.
      wr_before = wr_count;
      start_load(9'd1);
      send_byte(8'hAA);
      send_byte(8'hBB);
      t_last = cyc;
      wait_flag(1'b1, "tmo_err", t_err);
      check("tmo_idle_cycles", 64'(t_err - t_last), 64'(TIMEOUT));
      check("tmo_no_done", 64'(done), 0);
      tick();
      check("tmo_err_once", 64'(err), 0);
      check("tmo_idle", 64'(cpu_hold), 0);
      check("tmo_no_write", 64'(wr_count - wr_before), 0);

      // Reset after three bytes, then a clean reload.
      wr_before = wr_count;
      start_load(9'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      reset = 1'b1;
      tick();
      check_all_zero("midreset");
      reset = 1'b0;
      tick();
      check("midreset_no_write", 64'(wr_count - wr_before), 0);
      sb.push_back(wr_t'{addr: 8'd0, data: 32'hDEADBEEF});
      start_load(9'd1);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      wait_flag(1'b0, "reload_done", t_done);
      check("reload_writes", 64'(wr_count - wr_before), 1);
      tick();

      // Oversized count clamps to 256 words; stray starts mid-load are ignored.
      wr_before = wr_count;
      for (int i = 0; i < 256; i++) sb.push_back(wr_t'{addr: 8'(i), data: pat(i)});
      start_load(9'd300);
      for (int i = 0; i < 256; i++) begin
         w = pat(i);
         for (int b = 3; b >= 0; b--) begin
            send_byte(w[8*b +: 8]);
            if (b == 2 && (i == 100 || i == 200)) begin
               start      = 1'b1;
               word_count = 9'd5;
            end
            tick();
            start = 1'b0;
         end
      end
      wait_flag(1'b0, "big_done", t_done);
      check("big_writes", 64'(wr_count - wr_before), 256);
      check("big_last_addr", 64'(last_addr), 255);
      tick();
      check("big_idle", 64'(cpu_hold), 0);
      check("sb_drained", 64'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
